// File: rtl/seq_comparator.sv
// rtl/seq_comparator.sv - multi-cycle magnitude comparator, MSB chunk first, early exit
module seq_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             ALBO,
    output logic             AEBO,
    output logic             AGBO
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CMP  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_sign_flip;
    logic [IDXW-1:0]  r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    logic             w_accept;
    logic             w_finish;
    logic             w_lt;
    logic             w_eq;
    logic             w_gt;

    // Operands are shifted left each step, so the chunk under test is always the top one.
    assign w_chunk_a = r_a[WIDTH-1 -: CHUNK];
    assign w_chunk_b = r_b[WIDTH-1 -: CHUNK];

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_lt         = 1'b0;
        w_eq         = 1'b0;
        w_gt         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CMP;
                end
            end
            S_CMP: begin
                if (w_chunk_a != w_chunk_b) begin
                    w_finish     = 1'b1;
                    w_gt         = (w_chunk_a > w_chunk_b);
                    w_lt         = !(w_chunk_a > w_chunk_b);
                    w_state_next = S_IDLE;
                end else if (r_idx == LAST_IDX) begin
                    w_finish     = 1'b1;
                    w_eq         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_lt   <= 1'b0;
            r_eq   <= 1'b0;
            r_gt   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_a    <= a ^ w_sign_flip;
                r_b    <= b ^ w_sign_flip;
                r_idx  <= '0;
                r_busy <= 1'b1;
            end else if (r_state == S_CMP) begin
                if (w_finish) begin
                    r_busy <= 1'b0;
                    r_lt   <= w_lt;
                    r_eq   <= w_eq;
                    r_gt   <= w_gt;
                end else begin
                    r_a   <= r_a << CHUNK;
                    r_b   <= r_b << CHUNK;
                    r_idx <= r_idx + IDXW'(1);
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ALBO = r_lt;
    assign AEBO = r_eq;
    assign AGBO = r_gt;

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised, multi-cycle magnitude comparator: the WIDTH-bit successor to the team's 8-bit combinational comparator. It compares two WIDTH-bit operands CHUNK bits per cycle, most-significant chunk first, and stops early at the first differing chunk. It supports unsigned and two's-complement signed modes and keeps the ALBO/AEBO/AGBO result outputs, now registered and qualified by a start/busy/done handshake. It sits between operand registers and control logic wherever wide compares must not sit on a single-cycle critical path.

## Interface
- WIDTH, 32: operand width in bits. Must be ≥ 2 and an integer multiple of CHUNK.
- CHUNK, 8: bits compared per cycle. N = WIDTH/CHUNK is the number of chunks.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare. Accepted only on an edge where busy=0.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed. Sampled with start.
- a  input  WIDTH  operand A. Sampled with start.
- b  input  WIDTH  operand B. Sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse; the result outputs update on the same edge.
- ALBO  output  1  registered result: A < B.
- AEBO  output  1  registered result: A == B.
- AGBO  output  1  registered result: A > B.

## Operation
- States: IDLE and CMP. Internal registers: ra, rb (WIDTH bits each) and idx (0..N-1).
- IDLE, start=1:
  - Latch ra=a and rb=b.
  - If signed_mode=1, invert bit WIDTH-1 of both ra and rb at latch time. This maps signed order onto unsigned order.
  - Set idx=0, busy=1, then go to CMP.
- IDLE, start=0: hold all state.
- CMP, each edge: compare chunk idx, unsigned. Chunk idx is bits [WIDTH-1-idx·CHUNK -: CHUNK].
  - Chunks differ: set AGBO if ra chunk > rb chunk, else ALBO. Clear the other two flags. Pulse done, clear busy, go to IDLE.
  - Chunks equal, idx=N-1: set AEBO=1 and clear ALBO and AGBO. Pulse done, clear busy, go to IDLE.
  - Chunks equal, idx<N-1: increment idx and stay in CMP.
- Exactly one of ALBO/AEBO/AGBO is high after any completed compare.
- Result outputs hold their value from done until the next done. They do not change while busy=1.
- start while busy=1 is ignored. It is not queued, and a, b and signed_mode are not sampled.
- Changes on a, b or signed_mode after acceptance have no effect on the compare in progress.

## Timing
- Reset value of every output is 0: busy, done, ALBO, AEBO, AGBO.
- Reset also forces IDLE and idx=0.
- Reset asserted mid-compare aborts it immediately. done is not produced for the aborted compare.
- start is accepted at edge k. busy=1 from edge k.
- Let j be the index of the first differing chunk. done=1 and the results are valid from edge k+j+1, and done deasserts at edge k+j+2.
  - Minimum latency is 1 cycle: the MSB chunk differs.
  - Maximum latency is N cycles: operands equal, or only the LSB chunk differs.
- busy falls on the same edge that done rises.
- Back-to-back: during the done cycle the state is IDLE, so start=1 in that cycle is accepted at the next edge. Throughput is one compare per L+1 cycles at best.
- Case N=1 (CHUNK=WIDTH): every compare takes exactly 1 cycle.

## Test plan
Benches use WIDTH=32, CHUNK=8 unless noted.

- **Reset:** rst_n low, then high with start=0 → all outputs 0. Reset pulsed during CMP → busy=0 and done=0 on reset assertion, asynchronously; flags=0.
- **Early exit:** unsigned a=32'h8000_0000, b=32'h7FFF_FFFF → done 1 cycle after acceptance, AGBO=1. a=32'h1234_5600, b=32'h1234_5700 → done after 3 cycles, ALBO=1.
- **Equal / full latency:** a=b=32'hDEAD_BEEF → done after 4 cycles, AEBO=1, ALBO=AGBO=0.
- **Signed mode:**
  - a=32'hFFFF_FFFF (−1), b=32'h0000_0001 → ALBO=1 in 1 cycle.
  - Same operands with signed_mode=0 → AGBO=1.
  - a=32'h8000_0000 vs b=32'h8000_0001, signed → ALBO=1 after 4 cycles.
- **Handshake:**
  - start held high throughout a compare → the second compare begins only after done; busy never glitches.
  - a changed while busy → result reflects the latched a.
  - start asserted in the done cycle → next compare accepted on the following edge.
- **Parameter sweep and randomized check:** WIDTH=8/CHUNK=8 and WIDTH=16/CHUNK=4 → 10k random operand/mode pairs.
  - Flags match a reference $signed/$unsigned compare.
  - Exactly one flag is high.
  - Latency equals the first differing chunk index + 1, or N for equal operands.
